dmi_jtag_dtm: RTL and testbench



---
 rtl/dmi_jtag_dtm.sv | 189 ++++++++++++++++++
 tb/tb_dmi_jtag_dtm.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmi_jtag_dtm.sv
`timescale 1ns/1ps
// JTAG Debug Transport Module: oversampled TAP with IDCODE/DTMCS/DMI/BYPASS data registers,
// turning DMI scans into single-outstanding valid/ready requests toward the debug module.
module dmi_jtag_dtm #(
  parameter logic [31:0] IDCODE      = 32'h2000_0001,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        tck,
  input  logic        tms,
  input  logic        tdi,
  output logic        tdo,
  output logic        tdo_en,
  output logic        dmi_valid,
  input  logic        dmi_ready,
  output logic        dmi_write,
  output logic [6:0]  dmi_addr,
  output logic [31:0] dmi_wdata,
  input  logic [31:0] dmi_rdata
);

  localparam logic [4:0] IR_IDCODE = 5'h01;
  localparam logic [4:0] IR_DTMCS  = 5'h10;
  localparam logic [4:0] IR_DMI    = 5'h11;

  typedef enum logic [3:0] {
    TLR, RTI,
    SEL_DR, CAP_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPD_DR,
    SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPD_IR
  } tap_state_t;

  logic [SYNC_STAGES-1:0] r_tck_sync, r_tms_sync, r_tdi_sync;
  logic                   r_tck_prev;
  logic                   w_tck, w_tms, w_tdi, w_tck_rise, w_tck_fall;

  tap_state_t  r_state;
  logic [4:0]  r_ir, r_ir_sr;
  logic [40:0] r_dr, w_dr_capture, w_dr_shift;
  logic        r_sticky, r_valid, r_write;
  logic [6:0]  r_addr, r_last_addr;
  logic [31:0] r_wdata, r_last_data;
  logic        r_tdo, r_tdo_en;

  logic        w_match, w_pending, w_launch;
  logic [1:0]  w_cap_op, w_dmistat, w_upd_op;
  logic [31:0] w_cap_data;

  // All three pins share the same synchroniser depth so tms/tdi stay aligned with tck edges.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_tck_sync <= '0;
      r_tms_sync <= '0;
      r_tdi_sync <= '0;
      r_tck_prev <= 1'b0;
    end else begin
      r_tck_sync <= {r_tck_sync[SYNC_STAGES-2:0], tck};
      r_tms_sync <= {r_tms_sync[SYNC_STAGES-2:0], tms};
      r_tdi_sync <= {r_tdi_sync[SYNC_STAGES-2:0], tdi};
      r_tck_prev <= w_tck;
    end
  end

  assign w_tck      = r_tck_sync[SYNC_STAGES-1];
  assign w_tms      = r_tms_sync[SYNC_STAGES-1];
  assign w_tdi      = r_tdi_sync[SYNC_STAGES-1];
  assign w_tck_rise = w_tck & ~r_tck_prev;
  assign w_tck_fall = ~w_tck & r_tck_prev;

  // A response landing on the capture clk counts as complete: fresh read data bypasses last_data.
  assign w_match    = r_valid & dmi_ready;
  assign w_pending  = r_valid & ~dmi_ready;
  assign w_cap_op   = (w_pending | r_sticky) ? 2'd3 : 2'd0;
  assign w_cap_data = (w_match & ~r_write) ? dmi_rdata : r_last_data;
  assign w_dmistat  = r_sticky ? 2'd3 : 2'd0;
  assign w_upd_op   = r_dr[1:0];
  assign w_launch   = ~r_valid & ~r_sticky & ((w_upd_op == 2'd1) | (w_upd_op == 2'd2));

  always_comb begin
    w_dr_capture = '0;
    case (r_ir)
      IR_IDCODE: w_dr_capture = {9'd0, IDCODE};
      IR_DTMCS:  w_dr_capture = {9'd0, 17'd0, 3'd1, w_dmistat, 6'd7, 4'd1};
      IR_DMI:    w_dr_capture = {r_last_addr, w_cap_data, w_cap_op};
      default:   w_dr_capture = '0;
    endcase
  end

  always_comb begin
    w_dr_shift = '0;
    case (r_ir)
      IR_IDCODE, IR_DTMCS: w_dr_shift = {9'd0, w_tdi, r_dr[31:1]};
      IR_DMI:              w_dr_shift = {w_tdi, r_dr[40:1]};
      default:             w_dr_shift = {40'd0, w_tdi};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= TLR;
      r_ir        <= IR_IDCODE;
      r_ir_sr     <= '0;
      r_dr        <= '0;
      r_sticky    <= 1'b0;
      r_valid     <= 1'b0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_last_addr <= '0;
      r_last_data <= '0;
      r_tdo       <= 1'b0;
      r_tdo_en    <= 1'b0;
    end else begin
      if (w_match) begin
        r_valid <= 1'b0;
        if (!r_write) r_last_data <= dmi_rdata;
      end

      if (w_tck_rise) begin
        case (r_state)
          TLR:      r_state <= w_tms ? TLR : RTI;
          RTI:      r_state <= w_tms ? SEL_DR : RTI;
          SEL_DR:   r_state <= w_tms ? SEL_IR : CAP_DR;
          CAP_DR: begin
            r_dr <= w_dr_capture;
            if (r_ir == IR_DMI && w_pending) r_sticky <= 1'b1;
            r_state <= w_tms ? EXIT1_DR : SHIFT_DR;
          end
          SHIFT_DR: begin
            r_dr    <= w_dr_shift;
            r_state <= w_tms ? EXIT1_DR : SHIFT_DR;
          end
          EXIT1_DR: r_state <= w_tms ? UPD_DR : PAUSE_DR;
          PAUSE_DR: r_state <= w_tms ? EXIT2_DR : PAUSE_DR;
          EXIT2_DR: r_state <= w_tms ? UPD_DR : SHIFT_DR;
          UPD_DR:   r_state <= w_tms ? SEL_DR : RTI;
          SEL_IR:   r_state <= w_tms ? TLR : CAP_IR;
          CAP_IR: begin
            r_ir_sr <= 5'b00001;
            r_state <= w_tms ? EXIT1_IR : SHIFT_IR;
          end
          SHIFT_IR: begin
            r_ir_sr <= {w_tdi, r_ir_sr[4:1]};
            r_state <= w_tms ? EXIT1_IR : SHIFT_IR;
          end
          EXIT1_IR: r_state <= w_tms ? UPD_IR : PAUSE_IR;
          PAUSE_IR: r_state <= w_tms ? EXIT2_IR : PAUSE_IR;
          EXIT2_IR: r_state <= w_tms ? UPD_IR : SHIFT_IR;
          UPD_IR:   r_state <= w_tms ? SEL_DR : RTI;
          default:  r_state <= TLR;
        endcase
      end

      if (w_tck_fall) begin
        r_tdo_en <= (r_state == SHIFT_IR) || (r_state == SHIFT_DR);
        r_tdo    <= (r_state == SHIFT_IR) ? r_ir_sr[0] :
                    (r_state == SHIFT_DR) ? r_dr[0]    : 1'b0;
        if (r_state == UPD_IR) r_ir <= r_ir_sr;
        if (r_state == UPD_DR) begin
          if (r_ir == IR_DTMCS) begin
            if (r_dr[17]) begin
              r_sticky    <= 1'b0;
              r_last_addr <= '0;
              r_last_data <= '0;
            end else if (r_dr[16]) begin
              r_sticky <= 1'b0;
            end
          end else if (r_ir == IR_DMI && w_launch) begin
            r_valid     <= 1'b1;
            r_write     <= (w_upd_op == 2'd2);
            r_addr      <= r_dr[40:34];
            r_wdata     <= r_dr[33:2];
            r_last_addr <= r_dr[40:34];
          end
        end
      end

      if (r_state == TLR) r_ir <= IR_IDCODE;
    end
  end

  assign tdo       = r_tdo;
  assign tdo_en    = r_tdo_en;
  assign dmi_valid = r_valid;
  assign dmi_write = r_write;
  assign dmi_addr  = r_addr;
  assign dmi_wdata = r_wdata;

endmodule

// File: tb/tb_dmi_jtag_dtm.sv
`timescale 1ns/1ps
// Bench for dmi_jtag_dtm: drives JTAG scans, a DMI responder with a memory, and compares
// every scan against a stream-level model of the TAP data registers and DMI bookkeeping.
module tb_dmi_jtag_dtm;
  localparam logic [31:0] IDC = 32'h2000_0001;

  logic        clk, resetn, tck, tms, tdi, tdo, tdo_en;
  logic        dmi_valid, dmi_ready, dmi_write;
  logic [6:0]  dmi_addr;
  logic [31:0] dmi_wdata, dmi_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  logic [4:0]  m_ir;
  logic [6:0]  m_last_addr, m_pend_addr;
  logic [31:0] m_last_data, m_pend_data;
  logic        m_sticky, m_pending, m_pend_write;
  logic [31:0] m_mem [128];
  logic [31:0] resp_mem [128];
  logic [39:0] exp_q [$];
  logic [39:0] act_q [$];
  logic [39:0] last_act;
  int          m_launches = 0;
  int          vld_rises  = 0;
  logic        hold_ready;

  dmi_jtag_dtm #(.IDCODE(IDC), .SYNC_STAGES(2)) dut (
    .clk(clk), .resetn(resetn), .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo), .tdo_en(tdo_en),
    .dmi_valid(dmi_valid), .dmi_ready(dmi_ready), .dmi_write(dmi_write),
    .dmi_addr(dmi_addr), .dmi_wdata(dmi_wdata), .dmi_rdata(dmi_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, tests %0d", n_tests);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Responder: accepts one clk after it sees valid unless held off.
  initial begin
    dmi_ready = 1'b0;
    dmi_rdata = 32'h0;
    last_act  = '0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        dmi_ready = 1'b0;
      end else if (dmi_ready) begin
        dmi_ready = 1'b0;
        dmi_rdata = $urandom;
      end else if (dmi_valid && !hold_ready) begin
        last_act = {dmi_write, dmi_addr, dmi_wdata};
        act_q.push_back(last_act);
        if (dmi_write) resp_mem[dmi_addr] = dmi_wdata;
        else           dmi_rdata = resp_mem[dmi_addr];
        dmi_ready = 1'b1;
      end
    end
  end

  initial begin
    logic        pv;
    logic [39:0] saved;
    pv = 1'b0;
    saved = '0;
    forever begin
      @(negedge clk);
      if (dmi_valid && !pv) vld_rises++;
      if (dmi_valid && pv) chk("req_stable", 64'({dmi_write, dmi_addr, dmi_wdata}), 64'(saved));
      pv = dmi_valid;
      saved = {dmi_write, dmi_addr, dmi_wdata};
    end
  end

  task automatic jtag_cycle(input logic tms_v, input logic tdi_v, output logic tdo_v, output logic en_v);
    tms = tms_v;
    tdi = tdi_v;
    repeat (5) @(negedge clk);
    tdo_v = tdo;
    en_v  = tdo_en;
    tck = 1'b1;
    repeat (5) @(negedge clk);
    tck = 1'b0;
  endtask

  task automatic tap_reset();
    logic o, e;
    for (int i = 0; i < 5; i++) jtag_cycle(1'b1, 1'b0, o, e);
    jtag_cycle(1'b0, 1'b0, o, e);
    m_ir = 5'h01;
  endtask

  task automatic scan_ir(input logic [4:0] v);
    logic o, e;
    logic [4:0] cap;
    jtag_cycle(1'b1, 1'b0, o, e);
    jtag_cycle(1'b1, 1'b0, o, e);
    jtag_cycle(1'b0, 1'b0, o, e);
    jtag_cycle(1'b0, 1'b0, o, e);
    for (int i = 0; i < 5; i++) begin
      jtag_cycle(i == 4, v[i], o, e);
      cap[i] = o;
    end
    jtag_cycle(1'b1, 1'b0, o, e);
    jtag_cycle(1'b0, 1'b0, o, e);
    chk("ir_capture", 64'(cap), 64'd1);
    m_ir = v;
  endtask

  // Out stream = captured bits then shifted-in bits; the register keeps the window after n shifts.
  function automatic void stream(input int len, input logic [63:0] cap, input int n,
                                 input logic [63:0] din, output logic [63:0] dout,
                                 output logic [63:0] dr);
    logic s [0:127];
    for (int j = 0; j < 128; j++) s[j] = 1'b0;
    for (int j = 0; j < len; j++) s[j] = cap[j];
    for (int i = 0; i < n; i++) s[len+i] = din[i];
    dout = '0;
    dr   = '0;
    for (int i = 0; i < n; i++) dout[i] = s[i];
    for (int j = 0; j < len; j++) dr[j] = s[n+j];
  endfunction

  function automatic logic [63:0] dmi_word(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op);
    return {23'd0, a, d, op};
  endfunction

  task automatic m_complete();
    if (m_pend_write) m_mem[m_pend_addr] = m_pend_data;
    else              m_last_data = m_mem[m_pend_addr];
    exp_q.push_back({m_pend_write, m_pend_addr, m_pend_data});
    m_pending = 1'b0;
  endtask

  task automatic check_txns();
    chk("txn_count", 64'(act_q.size()), 64'(exp_q.size()));
    while (act_q.size() > 0 && exp_q.size() > 0)
      chk("txn_fields", 64'(act_q.pop_front()), 64'(exp_q.pop_front()));
    act_q.delete();
    exp_q.delete();
    chk("valid_launches", 64'(vld_rises), 64'(m_launches));
  endtask

  task automatic do_dr(input int n, input logic [63:0] din, output logic [63:0] dout);
    int          len;
    logic [63:0] cap, exp_out, dr, mask;
    logic        o, e, en_ok, idle_tdo, idle_en;
    if (m_ir == 5'h01) begin
      len = 32; cap = 64'(IDC);
    end else if (m_ir == 5'h10) begin
      len = 32; cap = m_sticky ? 64'h1C71 : 64'h1071;
    end else if (m_ir == 5'h11) begin
      len = 41;
      cap = dmi_word(m_last_addr, m_last_data, (m_pending || m_sticky) ? 2'd3 : 2'd0);
      if (m_pending) m_sticky = 1'b1;
    end else begin
      len = 1; cap = '0;
    end
    stream(len, cap, n, din, exp_out, dr);

    en_ok = 1'b1;
    dout  = '0;
    jtag_cycle(1'b1, 1'b0, o, e);
    jtag_cycle(1'b0, 1'b0, o, e);
    jtag_cycle(1'b0, 1'b0, o, e);
    for (int i = 0; i < n; i++) begin
      jtag_cycle(i == n - 1, din[i], o, e);
      dout[i] = o;
      en_ok &= e;
    end
    jtag_cycle(1'b1, 1'b0, o, e);
    jtag_cycle(1'b0, 1'b0, idle_tdo, idle_en);

    mask = (64'd1 << n) - 64'd1;
    chk($sformatf("dr_out_ir%02h", m_ir), dout & mask, exp_out & mask);
    chk("tdo_en_shift", 64'(en_ok), 64'd1);
    chk("tdo_idle", 64'({idle_en, idle_tdo}), 64'd0);

    if (m_ir == 5'h10) begin
      if (dr[17]) begin
        m_sticky = 1'b0; m_last_addr = '0; m_last_data = '0;
      end else if (dr[16]) begin
        m_sticky = 1'b0;
      end
    end else if (m_ir == 5'h11 && !m_pending && !m_sticky && (dr[1:0] == 2'd1 || dr[1:0] == 2'd2)) begin
      m_launches++;
      m_pending    = 1'b1;
      m_pend_write = (dr[1:0] == 2'd2);
      m_pend_addr  = dr[40:34];
      m_pend_data  = dr[33:2];
      m_last_addr  = dr[40:34];
      if (!hold_ready) m_complete();
    end
    repeat (12) @(negedge clk);
    check_txns();
  endtask

  task automatic release_hold();
    hold_ready = 1'b0;
    if (m_pending) m_complete();
    repeat (12) @(negedge clk);
    check_txns();
  endtask

  task automatic model_reset();
    m_ir = 5'h01; m_last_addr = '0; m_last_data = '0;
    m_sticky = 1'b0; m_pending = 1'b0;
  endtask

  initial begin
    logic [63:0] d;
    logic [31:0] w;
    logic [4:0]  v;
    int          r0, k;
    logic        o, e;

    tck = 1'b0; tms = 1'b0; tdi = 1'b0; hold_ready = 1'b0;
    m_pend_addr = '0; m_pend_data = '0; m_pend_write = 1'b0;
    for (int i = 0; i < 128; i++) begin
      w = $urandom;
      m_mem[i] = w;
      resp_mem[i] = w;
    end
    m_mem[7'h11] = 32'h0000_0C82;
    resp_mem[7'h11] = 32'h0000_0C82;
    model_reset();

    resetn = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_outputs", 64'({dmi_valid, dmi_write, tdo, tdo_en}), 64'd0);
    chk("rst_req", 64'({dmi_addr, dmi_wdata}), 64'd0);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    tap_reset();

    // IDCODE after reset
    do_dr(32, 64'($urandom), d);
    chk("idcode", d[31:0], 64'(IDC));

    // DTMCS nominal
    scan_ir(5'h10);
    do_dr(32, 64'd0, d);
    chk("dtmcs_nominal", d[31:0], 64'h1071);

    // DMI write then read-back of captured status
    scan_ir(5'h11);
    r0 = vld_rises;
    do_dr(41, dmi_word(7'h04, 32'hDEADBEEF, 2'd2), d);
    chk("write_one_valid", 64'(vld_rises - r0), 64'd1);
    chk("write_txn", 64'(last_act), 64'({1'b1, 7'h04, 32'hDEADBEEF}));
    do_dr(41, 64'd0, d);
    chk("after_write_addr_op", 64'({d[40:34], d[1:0]}), 64'({7'h04, 2'd0}));

    // DMI read
    do_dr(41, dmi_word(7'h11, 32'h0, 2'd1), d);
    do_dr(41, 64'd0, d);
    chk("read_capture", d, dmi_word(7'h11, 32'h0000_0C82, 2'd0));

    // Busy: responder stalls
    hold_ready = 1'b1;
    do_dr(41, dmi_word(7'h05, 32'h0, 2'd1), d);
    chk("held_valid", 64'(dmi_valid), 64'd1);
    r0 = vld_rises;
    do_dr(41, dmi_word(7'h06, 32'h1234_5678, 2'd2), d);
    chk("busy_op", 64'(d[1:0]), 64'd3);
    chk("busy_no_new_valid", 64'(vld_rises - r0), 64'd0);
    scan_ir(5'h10);
    do_dr(32, 64'd0, d);
    chk("dtmcs_busy", d[31:0], 64'h1C71);
    release_hold();
    do_dr(32, 64'h0001_0000, d);
    do_dr(32, 64'd0, d);
    chk("dtmcs_cleared", d[31:0], 64'h1071);
    scan_ir(5'h11);
    do_dr(41, 64'd0, d);
    chk("dmi_op_cleared", 64'(d[1:0]), 64'd0);

    // BYPASS delays by one bit
    scan_ir(5'h1F);
    do_dr(8, 64'hA5, d);
    chk("bypass", 64'(d[7:0]), 64'h4A);

    // Reset mid-request
    scan_ir(5'h11);
    hold_ready = 1'b1;
    do_dr(41, dmi_word(7'h22, 32'hCAFE_F00D, 2'd2), d);
    chk("pre_reset_valid", 64'(dmi_valid), 64'd1);
    resetn = 1'b0;
    @(negedge clk);
    chk("reset_valid", 64'({dmi_valid, dmi_write}), 64'd0);
    chk("reset_req", 64'({dmi_addr, dmi_wdata}), 64'd0);
    resetn = 1'b1;
    hold_ready = 1'b0;
    model_reset();
    repeat (12) @(negedge clk);
    jtag_cycle(1'b0, 1'b0, o, e);
    do_dr(32, 64'd0, d);
    chk("ir_after_reset", d[31:0], 64'(IDC));

    // Randomized scans against the model
    for (int it = 0; it < 30; it++) begin
      k = $urandom_range(0, 9);
      if (k == 0) begin
        v = 5'($urandom_range(0, 31));
        scan_ir(v);
      end else if (k <= 5) begin
        if (m_ir != 5'h11) scan_ir(5'h11);
        do_dr(41, dmi_word(7'($urandom_range(0, 7)), $urandom, 2'($urandom_range(0, 3))), d);
      end else if (k == 6) begin
        if (m_ir != 5'h10) scan_ir(5'h10);
        w = $urandom;
        w[17:16] = 2'b00;
        r0 = $urandom_range(0, 5);
        if (r0 == 0) w[16] = 1'b1;
        if (r0 == 1) w[17] = 1'b1;
        do_dr(32, 64'(w), d);
      end else if (k == 7) begin
        if (hold_ready) release_hold();
        else hold_ready = 1'b1;
      end else if (k == 8) begin
        d = {$urandom, $urandom};
        do_dr($urandom_range(1, 41), d, d);
      end else begin
        tap_reset();
      end
    end
    if (hold_ready) release_hold();
    check_txns();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
